// File: rtl/aes_inv_req_arb_if.sv
// Requester, pipe and response signals of the inverse-cipher request arbiter.
// The arbiter connects through the slave modport and the environment through master.
interface aes_inv_req_arb_if;
    logic [3:0]        req_valid;
    logic [3:0][127:0] req_data;
    logic [3:0]        req_ready;

    logic              pipe_data_in_valid;
    logic [127:0]      pipe_data_in;
    logic [127:0]      pipe_key;
    logic              pipe_data_out_valid;
    logic [127:0]      pipe_data_out;

    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [127:0]      rsp_data;

    modport slave (
        input  req_valid, req_data, pipe_data_out_valid, pipe_data_out,
        output req_ready, pipe_data_in_valid, pipe_data_in, pipe_key,
               rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_data, pipe_data_out_valid, pipe_data_out,
        input  req_ready, pipe_data_in_valid, pipe_data_in, pipe_key,
               rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/aes_inv_req_arb.sv
// Four-way round-robin arbiter feeding a shared inverse-cipher pipe; the key is only
// switched once the pipe is empty, and results are tagged back to their requester.
module aes_inv_req_arb #(
    parameter int unsigned MAX_INFLIGHT = 25,
    parameter int unsigned TAG_DEPTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_id,
    input  logic [127:0]            cfg_key,
    aes_inv_req_arb_if.slave        bus,
    output logic [4:0]              inflight,
    output logic                    err_underflow
);
    localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StSwitch} state_e;

    state_e          state_q;
    logic [1:0]      rr_ptr_q;
    logic [1:0]      owner_q;
    logic [1:0]      sw_tgt_q;
    logic            key_dirty_q;
    logic [127:0]    active_key_q;
    logic [127:0]    slot_q [4];

    logic [1:0]      tag_mem [TAG_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] tag_cnt_q;

    logic [1:0]      cand;
    logic            any_valid;
    logic            need_switch;
    logic            can_issue;
    logic            accept;
    logic            pop;
    logic            tag_empty;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == TAG_DEPTH - 1) ? '0 : p + PtrW'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        cand  = rr_ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && bus.req_valid[idx]) begin
                cand  = idx;
                found = 1'b1;
            end
        end
    end

    assign any_valid   = |bus.req_valid;
    assign need_switch = (cand != owner_q) || key_dirty_q;
    assign tag_empty   = (tag_cnt_q == '0);
    assign can_issue   = (state_q == StIssue) && any_valid && !need_switch &&
                         (32'(inflight) < MAX_INFLIGHT);
    assign accept      = can_issue;
    assign pop         = bus.pipe_data_out_valid && !tag_empty;

    always_comb begin
        bus.req_ready = '0;
        if (can_issue) begin
            bus.req_ready[cand] = 1'b1;
        end
    end

    assign bus.pipe_key = active_key_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr_q] <= cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= StIdle;
            rr_ptr_q               <= '0;
            owner_q                <= '0;
            sw_tgt_q               <= '0;
            key_dirty_q            <= 1'b1;
            active_key_q           <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q               <= '0;
            rd_ptr_q               <= '0;
            tag_cnt_q              <= '0;
            inflight               <= '0;
            err_underflow          <= 1'b0;
            bus.pipe_data_in_valid <= 1'b0;
            bus.pipe_data_in       <= '0;
            bus.rsp_valid          <= 1'b0;
            bus.rsp_id             <= '0;
            bus.rsp_data           <= '0;
        end else begin
            if (cfg_we) begin
                slot_q[cfg_id] <= cfg_key;
                if (cfg_id == owner_q) begin
                    key_dirty_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        sw_tgt_q <= cand;
                        if (!need_switch) begin
                            state_q <= StIssue;
                        end else if (inflight != '0) begin
                            // Blocks still in the pipe: wait them out before touching the key.
                            state_q <= StDrain;
                        end else begin
                            state_q <= StSwitch;
                        end
                    end
                end
                StIssue: begin
                    if (!any_valid) begin
                        state_q <= StIdle;
                    end else if (need_switch) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (inflight == '0) begin
                        sw_tgt_q <= any_valid ? cand : owner_q;
                        state_q  <= StSwitch;
                    end
                end
                StSwitch: begin
                    // Nonblocking read sees the pre-write slot; a racing write re-dirties it.
                    active_key_q <= slot_q[sw_tgt_q];
                    owner_q      <= sw_tgt_q;
                    key_dirty_q  <= cfg_we && (cfg_id == sw_tgt_q);
                    state_q      <= StIssue;
                end
                default: state_q <= StIdle;
            endcase

            bus.pipe_data_in_valid <= accept;
            if (accept) begin
                bus.pipe_data_in <= bus.req_data[cand];
                rr_ptr_q         <= cand + 2'd1;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end

            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            case ({accept, pop})
                2'b10: begin
                    tag_cnt_q <= tag_cnt_q + CntW'(1);
                    inflight  <= inflight + 5'd1;
                end
                2'b01: begin
                    tag_cnt_q <= tag_cnt_q - CntW'(1);
                    inflight  <= inflight - 5'd1;
                end
                default: ;
            endcase

            if (bus.pipe_data_out_valid && tag_empty) begin
                err_underflow <= 1'b1;
            end

            bus.rsp_valid <= pop;
            if (pop) begin
                bus.rsp_id   <= tag_mem[rd_ptr_q];
                bus.rsp_data <= bus.pipe_data_out;
            end
        end
    end
endmodule
